// File: rtl/mul1024_pkg.sv
// Shared types and defaults for the 1024x1024 multiplier scheduler.
package mul1024_pkg;

  localparam int IW_DEF      = 1024;
  localparam int OW_DEF      = 2048;
  localparam int TIMEOUT_DEF = 8192;
  localparam int CW_DEF      = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester strictly after ptr,
// wrapping cyclically. Purely combinational; the caller owns the pointer.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Cyclic search starting one position above the pointer.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        any = 1'b1;
        idx = PW'((int'(ptr) + i) % NREQ);
        gnt[(int'(ptr) + i) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul1024_sched.sv
// Shares one wide signed multiplier core between NREQ requesters.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | wait for a request; latch winner operands and grant
// LOAD  | one cycle of enable+load to the core, timeout counter cleared
// RUN   | enable held, wait for core valid or timeout
// GAP   | enable low for one cycle to clear core; done/err pulse
module mul1024_sched
  import mul1024_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IW      = IW_DEF,
  parameter int OW      = OW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [NREQ-1:0]    iReq,
  input  logic [NREQ*IW-1:0] iX,
  input  logic [NREQ*IW-1:0] iY,
  output logic [NREQ-1:0]    oGnt,
  output logic [NREQ-1:0]    oDone,
  output logic [NREQ-1:0]    oErr,
  output logic [OW-1:0]      oZ,
  output logic               oBusy,
  output logic               oMulEnable,
  output logic               oMulLoad,
  output logic [IW-1:0]      oMulX,
  output logic [IW-1:0]      oMulY,
  input  logic               iMulDataValid,
  input  logic [OW-1:0]      iMulZ
);

  localparam int            PW       = $clog2(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   z_q, z_d;
  logic [IW-1:0]   x_q, x_d;
  logic [IW-1:0]   y_q, y_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req (iReq),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Next-state and datapath: arbitration in IDLE, capture/timeout in RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    cnt_d   = cnt_q;
    z_d     = z_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
              x_d = iX[k*IW +: IW];
              y_d = iY[k*IW +: IW];
            end
          end
          gnt_d   = arb_gnt;
          ptr_d   = arb_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Valid takes priority over a timeout landing in the same cycle.
        if (iMulDataValid) begin
          z_d     = iMulZ;
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; pointer resets so requester 0 wins first.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign oGnt       = gnt_q;
  assign oDone      = done_q;
  assign oErr       = err_q;
  assign oZ         = z_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oMulEnable = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign oMulLoad   = (state_q == ST_LOAD);
  assign oMulX      = x_q;
  assign oMulY      = y_q;

endmodule

// File: doc/mul1024_sched.md
Name: mul1024_sched

Overview:
- Round-robin scheduler that shares one 1024x1024 signed multiplier core between NREQ requesters, e.g. modular-exponentiation and key-generation engines in the SoC.
- Latches the winning requester's operands and sequences the core's enable/load protocol.
- Watches the core for completion or timeout, captures the 2048-bit product and returns it with a per-requester done/error pulse.
- Sits between the requesters and the multiplier core.

Parameters:
NREQ, 4, number of requesters (2..8)
IW, 1024, operand width
OW, 2048, product width
TIMEOUT, 8192, max cycles in RUN before abort
CW, 14, timeout counter width (>= clog2(TIMEOUT+1))

Ports:
iClk  in  1  clock, all logic on rising edge
iRst_n  in  1  asynchronous active-low reset
iReq  in  NREQ  per-requester request level
iX  in  NREQ*IW  operand X, requester k at [k*IW +: IW]
iY  in  NREQ*IW  operand Y, same packing
oGnt  out  NREQ  one-hot, owner of the core
oDone  out  NREQ  one-cycle pulse, product valid on oZ
oErr  out  NREQ  one-cycle pulse, operation timed out
oZ  out  OW  registered product, held until next capture
oBusy  out  1  high in any state other than IDLE
oMulEnable  out  1  to core iEnable
oMulLoad  out  1  to core iLoad
oMulX  out  IW  to core iX
oMulY  out  IW  to core iY
iMulDataValid  in  1  from core oDataValid
iMulZ  in  OW  from core oZ

Behaviour:
- Reset (async, iRst_n=0): state=IDLE. All outputs 0, including oZ, oMulX and oMulY. Round-robin pointer=NREQ-1, so requester 0 wins first. Counter=0.
- States: IDLE -> LOAD -> RUN -> GAP -> IDLE.
- IDLE:
  - If any iReq bit is set, choose the first requester above the pointer, searching cyclically.
  - Register that requester's iX/iY into oMulX/oMulY, set oGnt one-hot, update the pointer to the winner, go to LOAD.
  - With no request, stay in IDLE with all outputs idle.
- LOAD (1 cycle): oMulEnable=1, oMulLoad=1; counter cleared; go to RUN.
- RUN:
  - oMulEnable=1, oMulLoad=0; counter increments each cycle.
  - On the first cycle iMulDataValid=1: oZ<=iMulZ, oDone[owner]=1 on the next cycle, go to GAP.
  - If the counter reaches TIMEOUT-1 with no valid: oErr[owner]=1 on the next cycle, oZ unchanged, go to GAP.
  - If valid and timeout fall in the same cycle, valid wins and no oErr is raised.
- GAP (1 cycle):
  - oMulEnable=0, which clears the core's sign/state.
  - oGnt is cleared on entry to GAP; oDone/oErr are high in this cycle only.
  - Go to IDLE.
- Latency:
  - iReq sampled at cycle t gives oGnt and oMulLoad at t+1.
  - A core valid at cycle v gives oDone and oZ at v+1.
  - Back-to-back turnaround is 2 idle cycles (GAP, IDLE) between operations.
- Handshake:
  - A requester holds iReq, iX and iY until it sees oDone or oErr, then deasserts iReq within 1 cycle.
  - iReq still high in the next IDLE is treated as a new request; it is served only if it wins round-robin.
  - Operands are sampled only in IDLE. Changes during LOAD/RUN are ignored.
  - Dropping iReq during LOAD/RUN does not abort the operation; the result is still delivered via oDone.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0...; no requester waits more than NREQ-1 operations.
- iMulDataValid outside RUN is ignored.
- Reset mid-operation returns to IDLE immediately; oMulEnable=0 resets the core. The interrupted requester receives neither oDone nor oErr.

Decomposition:
- Shared package mul1024_pkg:
  - state enum (IDLE, LOAD, RUN, GAP).
  - IW/OW defaults and the TIMEOUT default.
- One sub-module rr_arb:
  - Combinational first-set-after-pointer search.
  - Inputs: NREQ-bit req vector and pointer.
  - Outputs: one-hot grant and winner index.
  - The scheduler owns the pointer register.

Test Plan:
- Single op: reset, iReq=0001, X=3, Y=5, core model returns valid 40 cycles after load with Z=15 -> oGnt=0001 at t+1, one oMulLoad pulse, oDone=0001 with oZ=15, oMulEnable low for exactly 1 cycle in GAP.
- Signed operands: X=-2 (two's complement, 1024 bits), Y=7 -> oMulX/oMulY equal the inputs bit-exact; oZ carries the core's product unchanged.
- Fairness: iReq=1111 held, each requester dropping for 1 cycle after its oDone -> grant order 0,1,2,3,0; no oErr.
- Timeout: TIMEOUT=16, core never asserts valid -> oErr[owner] pulses 16 cycles after RUN entry; oZ keeps its prior value; the next request is served normally.
- Valid/timeout coincide at counter=TIMEOUT-1 -> oDone only, no oErr.
- Reset in RUN: iRst_n low for 1 cycle mid-op -> all outputs 0 immediately, no oDone/oErr; after release, a pending iReq=0100 is granted (pointer reset, search starts from 0).
